// File: rtl/gray_to_binary.sv
// Gray-to-binary converter.
// Each output bit is the XOR of all Gray bits at and above its position. The
// prefix XOR uses a Kogge-Stone tree of ceil(log2(WIDTH)) levels. The result is
// registered and qualified by out_valid. With PIPELINED=1, an input register
// is followed by one register per prefix level. Every data stage loads only
// when its incoming valid bit is set, so binary keeps the last result between
// words.
module gray_to_binary #(
    parameter int WIDTH     = 4,
    parameter int PIPELINED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] gray,
    output logic             out_valid,
    output logic [WIDTH-1:0] binary
);

    localparam int unsigned W      = WIDTH;
    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;

    // One Kogge-Stone level: fold in the partial result 2^k positions above.
    function automatic logic [WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] x,
                                                      input int unsigned     k);
        logic [WIDTH-1:0] r;
        int unsigned      step;
        r    = x;
        step = 32'd1 << k;
        for (int unsigned i = 0; i < W; i++) begin
            if (i + step < W) begin
                r[i] = x[i] ^ x[i + step];
            end
        end
        return r;
    endfunction

    if (PIPELINED == 0) begin : g_comb

        logic [WIDTH-1:0] bin_d;
        logic [WIDTH-1:0] bin_q;
        logic             vld_q;

        // Full prefix XOR ahead of the single output register.
        always_comb begin
            bin_d = gray;
            for (int unsigned k = 0; (32'd1 << k) < W; k++) begin
                bin_d = prefix_level(bin_d, k);
            end
        end

        // Output register: loads on valid words and holds otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bin_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= in_valid;
                if (in_valid) begin
                    bin_q <= bin_d;
                end
            end
        end

        assign binary    = bin_q;
        assign out_valid = vld_q;

    end else begin : g_pipe

        // Stage 0 captures the raw Gray word. Stage k+1 holds the word after
        // prefix level k. The valid chain runs in parallel with the data stages.
        logic [WIDTH-1:0] stage_d [LEVELS+1];
        logic [WIDTH-1:0] stage_q [LEVELS+1];
        logic [LEVELS:0]  vld_q;

        // Next value of every stage, computed from the stage before it.
        always_comb begin
            for (int unsigned k = 0; k < LEVELS + 1; k++) begin
                stage_d[k] = '0;
            end
            stage_d[0] = gray;
            for (int unsigned k = 1; k < LEVELS + 1; k++) begin
                stage_d[k] = prefix_level(stage_q[k-1], k - 1);
            end
        end

        // Stage registers and valid chain. A stage loads only when valid reaches it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= '0;
                for (int unsigned k = 0; k < LEVELS + 1; k++) begin
                    stage_q[k] <= '0;
                end
            end else begin
                vld_q[0] <= in_valid;
                if (in_valid) begin
                    stage_q[0] <= stage_d[0];
                end
                for (int unsigned k = 1; k < LEVELS + 1; k++) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        stage_q[k] <= stage_d[k];
                    end
                end
            end
        end

        assign binary    = stage_q[LEVELS];
        assign out_valid = vld_q[LEVELS];

    end

endmodule

// File: tb/tb_gray_to_binary.sv
// Scoreboard bench for gray_to_binary. Six instances cover WIDTH 4/1/16 with
// PIPELINED 0/1, and all of them share one stimulus stream.
module tb_gray_to_binary;

    localparam int ND = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] g16;
    logic [3:0]  g4;
    logic [0:0]  g1;

    logic        ov40, ov41, ov10, ov11, ov160, ov161;
    logic [3:0]  b40, b41;
    logic [0:0]  b10, b11;
    logic [15:0] b160, b161;

    logic        ov_a  [ND];
    logic [15:0] bin_a [ND];

    int          wid [ND] = '{4, 4, 1, 1, 16, 16};
    int unsigned lat [ND] = '{1, 3, 1, 1, 1, 5};

    typedef struct {
        logic [15:0] val;
        int unsigned cyc;
    } exp_t;

    exp_t        q    [ND][$];
    logic [15:0] last [ND];

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    assign g4 = g16[3:0];
    assign g1 = g16[0:0];

    gray_to_binary #(.WIDTH(4), .PIPELINED(0)) u_w4p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g4), .out_valid(ov40), .binary(b40));
    gray_to_binary #(.WIDTH(4), .PIPELINED(1)) u_w4p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g4), .out_valid(ov41), .binary(b41));
    gray_to_binary #(.WIDTH(1), .PIPELINED(0)) u_w1p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g1), .out_valid(ov10), .binary(b10));
    gray_to_binary #(.WIDTH(1), .PIPELINED(1)) u_w1p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g1), .out_valid(ov11), .binary(b11));
    gray_to_binary #(.WIDTH(16), .PIPELINED(0)) u_w16p0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g16), .out_valid(ov160), .binary(b160));
    gray_to_binary #(.WIDTH(16), .PIPELINED(1)) u_w16p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .gray(g16), .out_valid(ov161), .binary(b161));

    assign ov_a[0] = ov40;  assign bin_a[0] = {12'b0, b40};
    assign ov_a[1] = ov41;  assign bin_a[1] = {12'b0, b41};
    assign ov_a[2] = ov10;  assign bin_a[2] = {15'b0, b10};
    assign ov_a[3] = ov11;  assign bin_a[3] = {15'b0, b11};
    assign ov_a[4] = ov160; assign bin_a[4] = b160;
    assign ov_a[5] = ov161; assign bin_a[5] = b161;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: bit i of the binary word is the parity of all Gray bits at or above i.
    function automatic logic [15:0] g2b(input logic [15:0] g, input int w);
        logic [15:0] m;
        logic [15:0] gm;
        logic [15:0] b;
        m  = (w >= 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
        gm = g & m;
        b  = '0;
        for (int i = 0; i < w; i++) begin
            b[i] = ^(gm >> i);
        end
        return b;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, req, cyc);
        end
    endtask

    task automatic send(input logic v, input logic [15:0] g);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = v;
        g16      = g;
        if (v) begin
            for (int d = 0; d < ND; d++) begin
                e.val = g2b(g, wid[d]);
                e.cyc = cyc;
                q[d].push_back(e);
            end
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("%s_valid_d%0d", tag, d), {31'b0, ov_a[d]}, 32'd0);
            chk($sformatf("%s_binary_d%0d", tag, d), {16'b0, bin_a[d]}, 32'd0);
        end
    endtask

    // Reset asserted away from any clock edge, so its effect must be immediate.
    task automatic mid_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero("async_rst");
        for (int d = 0; d < ND; d++) begin
            q[d].delete();
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pop and compare on out_valid, otherwise require binary to hold.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                last[d] = '0;
                chk($sformatf("rst_valid_d%0d", d), {31'b0, ov_a[d]}, 32'd0);
                chk($sformatf("rst_binary_d%0d", d), {16'b0, bin_a[d]}, 32'd0);
            end else if (ov_a[d]) begin
                if (q[d].size() == 0) begin
                    chk($sformatf("unexpected_valid_d%0d", d), 32'd1, 32'd0);
                end else begin
                    e = q[d].pop_front();
                    chk($sformatf("data_d%0d", d), {16'b0, bin_a[d]}, {16'b0, e.val});
                    chk($sformatf("latency_d%0d", d), cyc - e.cyc, lat[d]);
                    last[d] = e.val;
                end
            end else begin
                chk($sformatf("hold_d%0d", d), {16'b0, bin_a[d]}, {16'b0, last[d]});
            end
        end
    end

    initial begin
        int pend;
        rst      = 1'b1;
        in_valid = 1'b0;
        g16      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // Back-to-back sweep of all 4-bit codes.
        for (int i = 0; i < 16; i++) begin
            send(1'b1, 16'(i));
        end

        // Spot values and MSB-only boundaries for each width.
        send(1'b1, 16'h0006);
        send(1'b1, 16'h0008);
        send(1'b1, 16'h000F);
        send(1'b1, 16'h0003);
        send(1'b1, 16'h8000);
        send(1'b1, 16'h0000);
        send(1'b1, 16'hFFFF);

        // Gray toggles while in_valid is low, so every output must hold.
        for (int i = 0; i < 10; i++) begin
            send(1'b0, (i % 2 == 0) ? 16'h000F : 16'h0000);
        end

        // Randomized stream with gaps and a reset in the middle.
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                mid_reset();
            end
            send(($urandom_range(0, 3) != 0), 16'($urandom));
        end
        send(1'b0, 16'h0000);

        // Bounded drain of words still in flight.
        for (int t = 0; t < 40; t++) begin
            pend = 0;
            for (int d = 0; d < ND; d++) begin
                pend += q[d].size();
            end
            if (pend == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("drain_d%0d", d), q[d].size(), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
